// File: rtl/nearest_k_tracker.sv
// K-nearest candidate list: sorted one-cycle insert, nearest-first drain over valid/ready.
// Optional `NEAREST_DEDUP_EN drops candidates whose vertex id is already held.
module nearest_k_tracker #(
  parameter int K      = 8,
  parameter int DIST_W = 32,
  parameter int ID_W   = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic                     valid_in,
  input  logic [DIST_W-1:0]        distance_in,
  input  logic [ID_W-1:0]          vertex_id_in,
  input  logic                     last_in,
  output logic [DIST_W-1:0]        worst_dist_out,
  output logic [$clog2(K+1)-1:0]   count_out,
  output logic                     busy_out,
  output logic                     result_valid_out,
  input  logic                     result_ready_in,
  output logic [DIST_W-1:0]        result_dist_out,
  output logic [ID_W-1:0]          result_id_out,
  output logic                     result_last_out,
  output logic                     done_out,
  output logic                     drop_err_out
);

  localparam int CW = $clog2(K+1);
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DIST_W-1:0]   dist_q [K];
  logic [DIST_W-1:0]   dist_d [K];
  logic [ID_W-1:0]     id_q [K];
  logic [ID_W-1:0]     id_d [K];
  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       rd_idx_q, rd_idx_d;
  logic                res_valid_q, res_valid_d;
  logic [DIST_W-1:0]   res_dist_q, res_dist_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic                res_last_q, res_last_d;
  logic                done_q, done_d;
  logic                drop_err_q, drop_err_d;

  logic [K-1:0]        held;
  logic [K-1:0]        le;
  logic                dup;
  logic                insert_ok;
  logic [DIST_W-1:0]   ins_dist [K];
  logic [ID_W-1:0]     ins_id [K];
  logic [IW-1:0]       next_idx;

  // le is a thermometer code: le[i] set for every held entry that stays ahead of the candidate.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_cmp
      assign held[gi] = (CW'(gi) < count_q);
      assign le[gi]   = held[gi] && (dist_q[gi] <= distance_in);
      if (gi == 0) begin : g_head
        assign ins_dist[gi] = le[gi] ? dist_q[gi] : distance_in;
        assign ins_id[gi]   = le[gi] ? id_q[gi]   : vertex_id_in;
      end else begin : g_body
        assign ins_dist[gi] = le[gi] ? dist_q[gi] : (le[gi-1] ? distance_in  : dist_q[gi-1]);
        assign ins_id[gi]   = le[gi] ? id_q[gi]   : (le[gi-1] ? vertex_id_in : id_q[gi-1]);
      end
    end
  endgenerate

`ifdef NEAREST_DEDUP_EN
  logic [K-1:0] id_hit;
  generate
    for (gi = 0; gi < K; gi++) begin : g_dup
      assign id_hit[gi] = held[gi] && (id_q[gi] == vertex_id_in);
    end
  endgenerate
  assign dup = |id_hit;
`else
  assign dup = 1'b0;
`endif

  assign insert_ok = !le[K-1] && !dup;
  assign next_idx  = rd_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dist_d      = dist_q;
    id_d        = id_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    res_valid_d = res_valid_q;
    res_dist_d  = res_dist_q;
    res_id_d    = res_id_q;
    res_last_d  = res_last_q;
    done_d      = 1'b0;
    drop_err_d  = drop_err_q;

    if (start_in) begin
      state_d     = S_COLLECT;
      for (int i = 0; i < K; i++) begin
        dist_d[i] = '0;
        id_d[i]   = '0;
      end
      count_d     = '0;
      rd_idx_d    = '0;
      res_valid_d = 1'b0;
      res_dist_d  = '0;
      res_id_d    = '0;
      res_last_d  = 1'b0;
      drop_err_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_in) drop_err_d = 1'b1;
        end
        S_COLLECT: begin
          if (valid_in) begin
            if (insert_ok) begin
              dist_d = ins_dist;
              id_d   = ins_id;
              if (count_q != CW'(K)) count_d = count_q + 1'b1;
            end
            if (last_in) begin
              state_d  = S_DRAIN;
              rd_idx_d = '0;
            end
          end
        end
        S_DRAIN: begin
          if (valid_in) drop_err_d = 1'b1;
          // The first DRAIN cycle loads beat 0 because the final insert only lands on entry.
          if (!res_valid_q) begin
            if (count_q == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              res_valid_d = 1'b1;
              res_dist_d  = dist_q[0];
              res_id_d    = id_q[0];
              res_last_d  = (count_q == CW'(1));
              rd_idx_d    = '0;
            end
          end else if (result_ready_in) begin
            if (res_last_q) begin
              res_valid_d = 1'b0;
              res_last_d  = 1'b0;
              done_d      = 1'b1;
              state_d     = S_IDLE;
            end else begin
              rd_idx_d   = next_idx;
              res_dist_d = dist_q[next_idx];
              res_id_d   = id_q[next_idx];
              res_last_d = (CW'(next_idx) == count_q - CW'(1));
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        id_q[i]   <= '0;
      end
      count_q     <= '0;
      rd_idx_q    <= '0;
      res_valid_q <= 1'b0;
      res_dist_q  <= '0;
      res_id_q    <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dist_q      <= dist_d;
      id_q        <= id_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      res_valid_q <= res_valid_d;
      res_dist_q  <= res_dist_d;
      res_id_q    <= res_id_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign worst_dist_out   = (count_q == CW'(K)) ? dist_q[K-1] : '1;
  assign count_out        = count_q;
  assign busy_out         = (state_q != S_IDLE);
  assign result_valid_out = res_valid_q;
  assign result_dist_out  = res_dist_q;
  assign result_id_out    = res_id_q;
  assign result_last_out  = res_last_q;
  assign done_out         = done_q;
  assign drop_err_out     = drop_err_q;

endmodule
